// File: rtl/sr_latch_ctrl_if.sv
// Requester-side bundle of sr_latch_ctrl: set/clear requests, their acks and the
// verified latch status. The FSM state is exported for checkers.
interface sr_latch_ctrl_if;
    // Handshake: set_req/clr_req are levels that the requester holds until the matching
    // one-cycle ack. Dropping a request before its ack withdraws it. Nothing is queued.
    logic       set_req;
    logic       clr_req;
    logic       set_ack;
    logic       clr_ack;
    logic       busy;
    logic       done;
    logic       err;
    logic       q_state;
    logic       q_valid;
    logic [1:0] state;

    modport master (
        output set_req, clr_req,
        input  set_ack, clr_ack, busy, done, err, q_state, q_valid, state
    );

    modport slave (
        input  set_req, clr_req,
        output set_ack, clr_ack, busy, done, err, q_state, q_valid, state
    );
endinterface

// File: rtl/sr_latch_ctrl.sv
// Sequencer for a NAND SR latch: arbitrates set/clear requests, drives timed active-low
// pulses on s_n/r_n and verifies the synchronised Q/Qn feedback.
module sr_latch_ctrl #(
    parameter int PULSE_CYC   = 4,
    parameter int SETTLE_CYC  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    sr_latch_ctrl_if.slave  bus,
    output logic            s_n,
    output logic            r_n,
    input  logic            q_fb,
    input  logic            qn_fb
);
    localparam int MAX_CYC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

    if (PULSE_CYC < 1) begin : g_bad_pulse
        $error("PULSE_CYC must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    // Feedback must have crossed the synchroniser before CHECK samples it.
    if (SETTLE_CYC < SYNC_STAGES + 1) begin : g_bad_settle
        $error("SETTLE_CYC must be at least SYNC_STAGES+1");
    end

    typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic                   target, target_nx;
    logic                   last_set, last_set_nx;
    logic                   s_n_nx, r_n_nx;
    logic                   set_ack_nx, clr_ack_nx, done_nx;
    logic                   err_nx, q_state_nx, q_valid_nx;
    logic                   grant_set, fb_ok;
    logic [SYNC_STAGES-1:0] q_sync, qn_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync  <= '0;
            qn_sync <= '0;
        end else begin
            q_sync  <= {q_sync[SYNC_STAGES-2:0], q_fb};
            qn_sync <= {qn_sync[SYNC_STAGES-2:0], qn_fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            target      <= 1'b0;
            last_set    <= 1'b0;
            s_n         <= 1'b1;
            r_n         <= 1'b1;
            bus.set_ack <= 1'b0;
            bus.clr_ack <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            bus.q_state <= 1'b0;
            bus.q_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            target      <= target_nx;
            last_set    <= last_set_nx;
            s_n         <= s_n_nx;
            r_n         <= r_n_nx;
            bus.set_ack <= set_ack_nx;
            bus.clr_ack <= clr_ack_nx;
            bus.done    <= done_nx;
            bus.err     <= err_nx;
            bus.q_state <= q_state_nx;
            bus.q_valid <= q_valid_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        target_nx   = target;
        last_set_nx = last_set;
        s_n_nx      = 1'b1;
        r_n_nx      = 1'b1;
        set_ack_nx  = 1'b0;
        clr_ack_nx  = 1'b0;
        done_nx     = 1'b0;
        err_nx      = bus.err;
        q_state_nx  = bus.q_state;
        q_valid_nx  = bus.q_valid;
        // On a tie, set wins only if the previous tie went to clear.
        grant_set   = bus.set_req & (~bus.clr_req | ~last_set);
        fb_ok       = (q_sync[SYNC_STAGES-1] == target) && (qn_sync[SYNC_STAGES-1] == ~target);

        case (state)
            IDLE: begin
                if (bus.set_req || bus.clr_req) begin
                    if (bus.set_req && bus.clr_req) begin
                        last_set_nx = grant_set;
                    end
                    target_nx  = grant_set;
                    set_ack_nx = grant_set;
                    clr_ack_nx = ~grant_set;
                    s_n_nx     = ~grant_set;
                    r_n_nx     = grant_set;
                    cnt_nx     = '0;
                    state_nx   = PULSE;
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    cnt_nx   = '0;
                    state_nx = SETTLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                    s_n_nx = ~target;
                    r_n_nx = target;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nx   = '0;
                    state_nx = CHECK;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            CHECK: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
                if (fb_ok) begin
                    q_state_nx = target;
                    q_valid_nx = 1'b1;
                    err_nx     = 1'b0;
                end else begin
                    q_valid_nx = 1'b0;
                    err_nx     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy  = (state != IDLE);
    assign bus.state = state;
endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: behavioural NAND latch models, an expected-result queue
// checked at every done pulse, and a short run of a PULSE_CYC=1/SETTLE_CYC=3 variant.
module tb_sr_latch_ctrl;
    localparam int P   = 4;
    localparam int S   = 4;
    localparam int LAT = P + S + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sr_latch_ctrl_if bus ();
    sr_latch_ctrl_if bus2 ();
    logic s_n, r_n, q_fb, qn_fb;
    logic s_n2, r_n2, q_fb2, qn_fb2;

    sr_latch_ctrl #(.PULSE_CYC(P), .SETTLE_CYC(S), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .s_n(s_n), .r_n(r_n), .q_fb(q_fb), .qn_fb(qn_fb)
    );

    sr_latch_ctrl #(.PULSE_CYC(1), .SETTLE_CYC(3), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .s_n(s_n2), .r_n(r_n2), .q_fb(q_fb2), .qn_fb(qn_fb2)
    );

    // NAND latch: the driven side moves after one gate delay, the other after two.
    logic lq, lqn, force_q0;
    logic lq2, lqn2;
    initial begin
        lq = 1'b0; lqn = 1'b1; lq2 = 1'b0; lqn2 = 1'b1;
    end
    always @(s_n or r_n) begin
        if (!s_n && r_n) begin lq <= #1 1'b1; lqn <= #2 1'b0; end
        else if (s_n && !r_n) begin lqn <= #1 1'b1; lq <= #2 1'b0; end
    end
    always @(s_n2 or r_n2) begin
        if (!s_n2 && r_n2) begin lq2 <= #1 1'b1; lqn2 <= #2 1'b0; end
        else if (s_n2 && !r_n2) begin lqn2 <= #1 1'b1; lq2 <= #2 1'b0; end
    end
    assign q_fb   = force_q0 ? 1'b0 : lq;
    assign qn_fb  = lqn;
    assign q_fb2  = lq2;
    assign qn_fb2 = lqn2;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard entry: {granted_set, q_state, q_valid, err}
    logic [3:0] exp_q[$];

    bit act = 1'b0;
    bit g_set;
    int g_cyc;

    always @(negedge clk) begin
        int k;
        logic [3:0] e;
        chk("no_forbidden", ({s_n, r_n} == 2'b00), 1'b0);
        chk("no_forbidden2", ({s_n2, r_n2} == 2'b00), 1'b0);
        if (!rst_n) begin
            act = 1'b0;
        end else begin
            if (bus.set_ack || bus.clr_ack) begin
                chk("ack_when_idle", act, 1'b0);
                chk("ack_onehot", bus.set_ack & bus.clr_ack, 1'b0);
                chk("ack_pending", (exp_q.size() > 0), 1'b1);
                if (exp_q.size() > 0) chk("ack_dir", bus.set_ack, exp_q[0][3]);
                act   = 1'b1;
                g_cyc = cyc;
                g_set = bus.set_ack;
            end
            if (act) begin
                k = cyc - g_cyc;
                if (k < P) begin
                    chk("pulse_s_n", s_n, !g_set);
                    chk("pulse_r_n", r_n, g_set);
                end else if (k < LAT) begin
                    chk("settle_s_n", s_n, 1'b1);
                    chk("settle_r_n", r_n, 1'b1);
                end
                if (k >= 1 && k < LAT) chk("ack_single", bus.set_ack | bus.clr_ack, 1'b0);
                if (k < LAT) chk("busy_in_op", bus.busy, 1'b1);
                if (!bus.done && k >= LAT + 2) begin
                    chk("done_timeout", k, LAT);
                    act = 1'b0;
                end
            end
            if (bus.done) begin
                chk("done_in_op", act, 1'b1);
                chk("done_busy", bus.busy, 1'b0);
                if (act && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("done_latency", cyc - g_cyc, LAT);
                    chk("q_state", bus.q_state, e[2]);
                    chk("q_valid", bus.q_valid, e[1]);
                    chk("err", bus.err, e[0]);
                end
                act = 1'b0;
            end
        end
    end

    task automatic raise(input bit set, input logic [2:0] res);
        exp_q.push_back({set, res});
        if (set) bus.set_req = 1'b1;
        else bus.clr_req = 1'b1;
    endtask

    task automatic await_ack(input bit set, output int at);
        bit seen = 1'b0;
        at = -1;
        repeat (40) begin
            @(negedge clk);
            if (set ? bus.set_ack : bus.clr_ack) begin
                seen = 1'b1;
                at = cyc;
                break;
            end
        end
        chk(set ? "set_ack_seen" : "clr_ack_seen", seen, 1'b1);
        if (set) bus.set_req = 1'b0;
        else bus.clr_req = 1'b0;
    endtask

    task automatic await_idle();
        bit ok = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_reached", ok, 1'b1);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int at1, at2, g2;
        bit seen;
        bus.set_req = 1'b0; bus.clr_req = 1'b0;
        bus2.set_req = 1'b0; bus2.clr_req = 1'b0;
        force_q0 = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {s_n, r_n, bus.set_ack, bus.clr_ack, bus.busy, bus.done,
                           bus.err, bus.q_state, bus.q_valid}, 9'b110000000);
        chk("reset_state", bus.state, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single set, then single clear
        raise(1'b1, 3'b110); await_ack(1'b1, at1); await_idle();
        raise(1'b0, 3'b010); await_ack(1'b0, at1); await_idle();

        // Simultaneous requests straight after reset: set wins, clear follows
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        raise(1'b1, 3'b110);
        raise(1'b0, 3'b010);
        await_ack(1'b1, at1);
        await_ack(1'b0, at2);
        chk("rr_gap_first", at2 - at1, LAT + 1);
        await_idle();
        chk("tie_final_q", bus.q_state, 1'b0);

        // Second tie: round-robin hands it to clear
        raise(1'b0, 3'b010);
        raise(1'b1, 3'b110);
        await_ack(1'b0, at1);
        await_ack(1'b1, at2);
        chk("rr_gap_second", at2 - at1, LAT + 1);
        await_idle();
        chk("tie2_final_q", bus.q_state, 1'b1);

        // Feedback fault: Q held low during a set leaves q_state at its old value
        raise(1'b0, 3'b010); await_ack(1'b0, at1); await_idle();
        force_q0 = 1'b1;
        raise(1'b1, 3'b001); await_ack(1'b1, at1); await_idle();
        force_q0 = 1'b0;
        raise(1'b0, 3'b010); await_ack(1'b0, at1); await_idle();

        // Reset in the second pulse cycle
        raise(1'b1, 3'b110); await_ack(1'b1, at1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_s_n", s_n, 1'b1);
        chk("midrst_r_n", r_n, 1'b1);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_q_valid", bus.q_valid, 1'b0);
        exp_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_state", bus.state, 2'd0);
        raise(1'b0, 3'b010); await_ack(1'b0, at1); await_idle();

        // Short-pulse variant: done five edges after the grant
        bus2.set_req = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus2.set_ack) begin seen = 1'b1; break; end
        end
        chk("sweep_ack_seen", seen, 1'b1);
        g2 = cyc;
        chk("sweep_pulse_low", s_n2, 1'b0);
        bus2.set_req = 1'b0;
        @(negedge clk);
        chk("sweep_pulse_end", s_n2, 1'b1);
        seen = 1'b0;
        repeat (20) begin
            if (bus2.done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("sweep_done_seen", seen, 1'b1);
        chk("sweep_latency", cyc - g2, 5);
        chk("sweep_result", {bus2.q_state, bus2.q_valid, bus2.err}, 3'b110);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
